// File: rtl/dcache_write_unit.sv
// rtl/dcache_write_unit.sv - data-cache write engine: tag-checked stores, line fills, PLRU metadata, whole-cache flush
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid / req_ready          write request handshake
//   req_tagcheck                   1 = store (tag checked), 0 = fill to req_way
//   req_index/line/tag/way/data    request fields
//   flush_req                      start a whole-cache flush (sampled in IDLE)
//   dwr_en, dwr_index/line/way/data  data-array write port (one-cycle strobe)
//   resp_valid / resp_ready        response handshake
//   resp_hit, resp_way             hit flag and way written
//   resp_victim_way/dirty/tag      eviction candidate for a store miss
//   busy                           FSM not in IDLE
//   flush_done                     one-cycle pulse in the last flush cycle

module dcache_write_unit #(
    parameter int NUM_OF_SETS = 64,
    parameter int WAY_PER_SET = 4,
    parameter int TAG_SIZE    = 20,
    parameter int WORD_SIZE   = 32,
    parameter int LINE_W      = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_tagcheck,
    input  logic [$clog2(NUM_OF_SETS)-1:0] req_index,
    input  logic [LINE_W-1:0]              req_line,
    input  logic [TAG_SIZE-1:0]            req_tag,
    input  logic [$clog2(WAY_PER_SET)-1:0] req_way,
    input  logic [WORD_SIZE-1:0]           req_data,

    input  logic                           flush_req,

    output logic                           dwr_en,
    output logic [$clog2(NUM_OF_SETS)-1:0] dwr_index,
    output logic [LINE_W-1:0]              dwr_line,
    output logic [$clog2(WAY_PER_SET)-1:0] dwr_way,
    output logic [WORD_SIZE-1:0]           dwr_data,

    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_hit,
    output logic [$clog2(WAY_PER_SET)-1:0] resp_way,
    output logic [$clog2(WAY_PER_SET)-1:0] resp_victim_way,
    output logic                           resp_victim_dirty,
    output logic [TAG_SIZE-1:0]            resp_victim_tag,

    output logic                           busy,
    output logic                           flush_done
);

    localparam int IDX_W = $clog2(NUM_OF_SETS);
    localparam int WAY_W = $clog2(WAY_PER_SET);
    localparam logic [IDX_W-1:0] LAST_SET    = IDX_W'(NUM_OF_SETS - 1);
    localparam logic [IDX_W-1:0] LAST_SET_M1 = IDX_W'(NUM_OF_SETS - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t state_q;

    // Per-set metadata
    logic [TAG_SIZE-1:0]    tag_q   [NUM_OF_SETS][WAY_PER_SET];
    logic [WAY_PER_SET-1:0] valid_q [NUM_OF_SETS];
    logic [WAY_PER_SET-1:0] dirty_q [NUM_OF_SETS];
    logic [2:0]             plru_q  [NUM_OF_SETS];

    // Latched request / registered outputs
    logic                 lk_fill_q;
    logic [TAG_SIZE-1:0]  lk_tag_q;
    logic                 dwr_en_q;
    logic [IDX_W-1:0]     dwr_index_q;
    logic [LINE_W-1:0]    dwr_line_q;
    logic [WAY_W-1:0]     dwr_way_q;
    logic [WORD_SIZE-1:0] dwr_data_q;
    logic                 resp_valid_q;
    logic                 resp_hit_q;
    logic [WAY_W-1:0]     resp_way_q;
    logic [WAY_W-1:0]     resp_victim_way_q;
    logic                 resp_victim_dirty_q;
    logic [TAG_SIZE-1:0]  resp_victim_tag_q;
    logic [IDX_W-1:0]     flush_cnt_q;
    logic                 flush_done_q;

    // Tree PLRU, bits {b2,b1,b0}: b0 picks the half, b1/b2 pick within it.
    function automatic logic [1:0] plru_victim(input logic [2:0] p);
        return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n = p;
        if (!w[1]) begin
            n[0] = 1'b1;
            n[1] = ~w[0];
        end else begin
            n[0] = 1'b0;
            n[2] = ~w[0];
        end
        return n;
    endfunction

    // Lookup is evaluated in IDLE against the incoming request. Metadata only
    // changes at the LOOKUP edge or during FLUSH, so the result registered at
    // the accept edge is identical to a compare done during LOOKUP.
    logic [WAY_PER_SET-1:0] set_valid;
    logic [WAY_PER_SET-1:0] set_dirty;
    logic [2:0]             set_plru;
    logic [WAY_PER_SET-1:0] hit_vec;
    logic                   hit_any;
    logic [WAY_W-1:0]       hit_way;
    logic                   inv_any;
    logic [WAY_W-1:0]       inv_way;
    logic [WAY_W-1:0]       victim_way;
    logic                   victim_dirty;
    logic [TAG_SIZE-1:0]    victim_tag;
    logic [WAY_W-1:0]       sel_way;

    always_comb begin
        set_valid = valid_q[req_index];
        set_dirty = dirty_q[req_index];
        set_plru  = plru_q[req_index];
        hit_vec   = '0;
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_any   = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAY_PER_SET; w++) begin
            hit_vec[w] = set_valid[w] && (tag_q[req_index][w] == req_tag);
        end
        // Descending loops leave the lowest matching index as the winner.
        for (int w = WAY_PER_SET - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim_way   = inv_any ? inv_way : plru_victim(set_plru);
        victim_dirty = set_valid[victim_way] && set_dirty[victim_way];
        victim_tag   = tag_q[req_index][victim_way];
        if (!req_tagcheck) begin
            sel_way = req_way;
        end else if (hit_any) begin
            sel_way = hit_way;
        end else begin
            sel_way = victim_way;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= S_IDLE;
            lk_fill_q           <= 1'b0;
            lk_tag_q            <= '0;
            dwr_en_q            <= 1'b0;
            dwr_index_q         <= '0;
            dwr_line_q          <= '0;
            dwr_way_q           <= '0;
            dwr_data_q          <= '0;
            resp_valid_q        <= 1'b0;
            resp_hit_q          <= 1'b0;
            resp_way_q          <= '0;
            resp_victim_way_q   <= '0;
            resp_victim_dirty_q <= 1'b0;
            resp_victim_tag_q   <= '0;
            flush_cnt_q         <= '0;
            flush_done_q        <= 1'b0;
            for (int s = 0; s < NUM_OF_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < WAY_PER_SET; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    flush_done_q <= 1'b0;
                    if (flush_req) begin
                        state_q     <= S_FLUSH;
                        flush_cnt_q <= '0;
                    end else if (req_valid) begin
                        state_q             <= S_LOOKUP;
                        lk_fill_q           <= !req_tagcheck;
                        lk_tag_q            <= req_tag;
                        dwr_en_q            <= !req_tagcheck || hit_any;
                        dwr_index_q         <= req_index;
                        dwr_line_q          <= req_line;
                        dwr_way_q           <= sel_way;
                        dwr_data_q          <= req_data;
                        resp_hit_q          <= !req_tagcheck || hit_any;
                        resp_way_q          <= sel_way;
                        resp_victim_way_q   <= victim_way;
                        resp_victim_dirty_q <= victim_dirty;
                        resp_victim_tag_q   <= victim_tag;
                    end
                end

                S_LOOKUP: begin
                    dwr_en_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                    // dwr_en_q doubles as "hit or fill": a store miss leaves metadata alone.
                    if (dwr_en_q) begin
                        plru_q[dwr_index_q] <= plru_touch(plru_q[dwr_index_q], dwr_way_q);
                        if (lk_fill_q) begin
                            tag_q[dwr_index_q][dwr_way_q]   <= lk_tag_q;
                            valid_q[dwr_index_q][dwr_way_q] <= 1'b1;
                            dirty_q[dwr_index_q][dwr_way_q] <= 1'b0;
                        end else begin
                            dirty_q[dwr_index_q][dwr_way_q] <= 1'b1;
                        end
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                S_FLUSH: begin
                    valid_q[flush_cnt_q] <= '0;
                    dirty_q[flush_cnt_q] <= '0;
                    plru_q[flush_cnt_q]  <= '0;
                    if (flush_cnt_q == LAST_SET) begin
                        state_q      <= S_IDLE;
                        flush_done_q <= 1'b0;
                    end else begin
                        flush_cnt_q  <= flush_cnt_q + 1'b1;
                        // Raised one edge early so the pulse lands in the last-set cycle.
                        flush_done_q <= (flush_cnt_q == LAST_SET_M1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready         = (state_q == S_IDLE) && !flush_req;
    assign busy              = (state_q != S_IDLE);
    assign flush_done        = flush_done_q;
    assign dwr_en            = dwr_en_q;
    assign dwr_index         = dwr_index_q;
    assign dwr_line          = dwr_line_q;
    assign dwr_way           = dwr_way_q;
    assign dwr_data          = dwr_data_q;
    assign resp_valid        = resp_valid_q;
    assign resp_hit          = resp_hit_q;
    assign resp_way          = resp_way_q;
    assign resp_victim_way   = resp_victim_way_q;
    assign resp_victim_dirty = resp_victim_dirty_q;
    assign resp_victim_tag   = resp_victim_tag_q;

endmodule

// File: tb/tb_dcache_write_unit.sv
// tb/tb_dcache_write_unit.sv - directed self-checking bench for dcache_write_unit

module tb_dcache_write_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_tagcheck;
    logic [5:0]  req_index;
    logic [5:0]  req_line;
    logic [19:0] req_tag;
    logic [1:0]  req_way;
    logic [31:0] req_data;
    logic        flush_req;
    logic        dwr_en;
    logic [5:0]  dwr_index;
    logic [5:0]  dwr_line;
    logic [1:0]  dwr_way;
    logic [31:0] dwr_data;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [1:0]  resp_victim_way;
    logic        resp_victim_dirty;
    logic [19:0] resp_victim_tag;
    logic        busy;
    logic        flush_done;

    int n_cmp = 0;
    int n_err = 0;

    // Values captured by do_req
    logic        req_ok;
    int          c_dwr_cnt;
    logic        c_dwr_en1;
    logic [5:0]  c_dwr_index;
    logic [5:0]  c_dwr_line;
    logic [1:0]  c_dwr_way;
    logic [31:0] c_dwr_data;
    logic        c_rv1;
    logic        c_rv2;
    logic        c_hit;
    logic [1:0]  c_way;
    logic [1:0]  c_vway;
    logic        c_vdirty;
    logic [19:0] c_vtag;

    dcache_write_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_tagcheck      (req_tagcheck),
        .req_index         (req_index),
        .req_line          (req_line),
        .req_tag           (req_tag),
        .req_way           (req_way),
        .req_data          (req_data),
        .flush_req         (flush_req),
        .dwr_en            (dwr_en),
        .dwr_index         (dwr_index),
        .dwr_line          (dwr_line),
        .dwr_way           (dwr_way),
        .dwr_data          (dwr_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_victim_way   (resp_victim_way),
        .resp_victim_dirty (resp_victim_dirty),
        .resp_victim_tag   (resp_victim_tag),
        .busy              (busy),
        .flush_done        (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request, records the N+1 (LOOKUP) and N+2 (RESP) cycle views,
    // then consumes the response. Returns at #1 after the edge back into IDLE.
    task automatic do_req(input logic tc, input logic [5:0] idx, input logic [5:0] ln,
                          input logic [19:0] tg, input logic [1:0] wy, input logic [31:0] dt);
        req_ok       = 1'b0;
        c_dwr_cnt    = 0;
        req_valid    = 1'b1;
        req_tagcheck = tc;
        req_index    = idx;
        req_line     = ln;
        req_tag      = tg;
        req_way      = wy;
        req_data     = dt;
        for (int i = 0; i < 20 && !req_ok; i++) begin
            if (req_ready) req_ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid   = 1'b0;
        c_dwr_en1   = dwr_en;
        c_dwr_index = dwr_index;
        c_dwr_line  = dwr_line;
        c_dwr_way   = dwr_way;
        c_dwr_data  = dwr_data;
        c_rv1       = resp_valid;
        c_dwr_cnt  += int'(dwr_en);
        @(posedge clk); #1;
        c_rv2       = resp_valid;
        c_dwr_cnt  += int'(dwr_en);
        c_hit       = resp_hit;
        c_way       = resp_way;
        c_vway      = resp_victim_way;
        c_vdirty    = resp_victim_dirty;
        c_vtag      = resp_victim_tag;
        resp_ready  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (dwr_en !== 1'b0) begin n_err++; $display("FAIL reset_dwr_en: got %b want 0", dwr_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({dwr_index, dwr_line, dwr_way, dwr_data} !== 46'd0) begin n_err++; $display("FAIL reset_dwr_payload: got %h want 0", {dwr_index, dwr_line, dwr_way, dwr_data}); end
        n_cmp++; if ({resp_hit, resp_way, resp_victim_way, resp_victim_dirty, resp_victim_tag} !== 26'd0) begin n_err++; $display("FAIL reset_resp_payload: got %h want 0", {resp_hit, resp_way, resp_victim_way, resp_victim_dirty, resp_victim_tag}); end
        flush_req = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready_flush: got %b want 0", req_ready); end
        flush_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_miss_empty();
        do_req(1'b1, 6'd5, 6'd0, 20'h00123, 2'd0, 32'h1111_1111);
        n_cmp++; if (req_ok !== 1'b1) begin n_err++; $display("FAIL miss_empty_accept: got %b want 1", req_ok); end
        n_cmp++; if (c_dwr_cnt != 0) begin n_err++; $display("FAIL miss_empty_dwr_cnt: got %0d want 0", c_dwr_cnt); end
        n_cmp++; if (c_rv1 !== 1'b0) begin n_err++; $display("FAIL miss_empty_rv_lookup: got %b want 0", c_rv1); end
        n_cmp++; if (c_rv2 !== 1'b1) begin n_err++; $display("FAIL miss_empty_rv_resp: got %b want 1", c_rv2); end
        n_cmp++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL miss_empty_hit: got %b want 0", c_hit); end
        n_cmp++; if (c_vway !== 2'd0) begin n_err++; $display("FAIL miss_empty_vway: got %0d want 0", c_vway); end
        n_cmp++; if (c_vdirty !== 1'b0) begin n_err++; $display("FAIL miss_empty_vdirty: got %b want 0", c_vdirty); end
    endtask

    task automatic test_fill();
        do_req(1'b0, 6'd5, 6'd3, 20'h00123, 2'd2, 32'hDEAD_BEEF);
        n_cmp++; if (c_dwr_en1 !== 1'b1) begin n_err++; $display("FAIL fill_dwr_en: got %b want 1", c_dwr_en1); end
        n_cmp++; if (c_dwr_cnt != 1) begin n_err++; $display("FAIL fill_dwr_cnt: got %0d want 1", c_dwr_cnt); end
        n_cmp++; if ({c_dwr_index, c_dwr_line, c_dwr_way} !== {6'd5, 6'd3, 2'd2}) begin n_err++; $display("FAIL fill_dwr_addr: got %0d/%0d/%0d want 5/3/2", c_dwr_index, c_dwr_line, c_dwr_way); end
        n_cmp++; if (c_dwr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fill_dwr_data: got %h want deadbeef", c_dwr_data); end
        n_cmp++; if (c_rv2 !== 1'b1) begin n_err++; $display("FAIL fill_resp_valid: got %b want 1", c_rv2); end
        n_cmp++; if (c_hit !== 1'b1) begin n_err++; $display("FAIL fill_hit: got %b want 1", c_hit); end
        n_cmp++; if (c_way !== 2'd2) begin n_err++; $display("FAIL fill_way: got %0d want 2", c_way); end
    endtask

    // Issued directly after the fill response, so it also exercises metadata visibility.
    task automatic test_store_hit();
        do_req(1'b1, 6'd5, 6'd7, 20'h00123, 2'd0, 32'hCAFE_F00D);
        n_cmp++; if (c_hit !== 1'b1) begin n_err++; $display("FAIL hit_hit: got %b want 1", c_hit); end
        n_cmp++; if (c_way !== 2'd2) begin n_err++; $display("FAIL hit_way: got %0d want 2", c_way); end
        n_cmp++; if (c_dwr_en1 !== 1'b1) begin n_err++; $display("FAIL hit_dwr_en: got %b want 1", c_dwr_en1); end
        n_cmp++; if ({c_dwr_index, c_dwr_line, c_dwr_way} !== {6'd5, 6'd7, 2'd2}) begin n_err++; $display("FAIL hit_dwr_addr: got %0d/%0d/%0d want 5/7/2", c_dwr_index, c_dwr_line, c_dwr_way); end
        n_cmp++; if (c_dwr_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL hit_dwr_data: got %h want cafef00d", c_dwr_data); end
    endtask

    // PLRU after hit on way 2 is 100; fills of ways 3,0,1 give 000, 011, 001 -> victim way 2.
    task automatic test_dirty_victim();
        do_req(1'b0, 6'd5, 6'd0, 20'h00301, 2'd3, 32'h0);
        do_req(1'b0, 6'd5, 6'd0, 20'h00302, 2'd0, 32'h0);
        do_req(1'b0, 6'd5, 6'd0, 20'h00303, 2'd1, 32'h0);
        do_req(1'b1, 6'd5, 6'd1, 20'h00999, 2'd0, 32'h5555_AAAA);
        n_cmp++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL dvict_hit: got %b want 0", c_hit); end
        n_cmp++; if (c_vway !== 2'd2) begin n_err++; $display("FAIL dvict_vway: got %0d want 2", c_vway); end
        n_cmp++; if (c_vdirty !== 1'b1) begin n_err++; $display("FAIL dvict_vdirty: got %b want 1", c_vdirty); end
        n_cmp++; if (c_vtag !== 20'h00123) begin n_err++; $display("FAIL dvict_vtag: got %h want 00123", c_vtag); end
        n_cmp++; if (c_dwr_cnt != 0) begin n_err++; $display("FAIL dvict_dwr_cnt: got %0d want 0", c_dwr_cnt); end
    endtask

    // Fills of ways 0..3 in order leave PLRU at 000 -> victim way 0.
    task automatic test_plru_full();
        for (int w = 0; w < 4; w++) begin
            do_req(1'b0, 6'd7, 6'd0, 20'h00700 + 20'(w), 2'(w), 32'h0);
        end
        do_req(1'b1, 6'd7, 6'd0, 20'h007FF, 2'd0, 32'h0);
        n_cmp++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL plru_hit: got %b want 0", c_hit); end
        n_cmp++; if (c_vway !== 2'd0) begin n_err++; $display("FAIL plru_vway: got %0d want 0", c_vway); end
        n_cmp++; if (c_vdirty !== 1'b0) begin n_err++; $display("FAIL plru_vdirty: got %b want 0", c_vdirty); end
        n_cmp++; if (c_vtag !== 20'h00700) begin n_err++; $display("FAIL plru_vtag: got %h want 00700", c_vtag); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 6'd9, 6'd4, 20'h00ABC, 2'd1, 32'h0BAD_CAFE);
        do_req(1'b1, 6'd9, 6'd4, 20'h00ABC, 2'd0, 32'h1234_5678);
        n_cmp++; if (c_hit !== 1'b1) begin n_err++; $display("FAIL b2b_hit: got %b want 1", c_hit); end
        n_cmp++; if (c_way !== 2'd1) begin n_err++; $display("FAIL b2b_way: got %0d want 1", c_way); end
        n_cmp++; if (c_dwr_data !== 32'h1234_5678) begin n_err++; $display("FAIL b2b_dwr_data: got %h want 12345678", c_dwr_data); end
    endtask

    task automatic test_resp_hold();
        logic ok;
        ok           = 1'b0;
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_tagcheck = 1'b1;
        req_index    = 6'd7;
        req_line     = 6'd2;
        req_tag      = 20'h00701;
        req_way      = 2'd0;
        req_data     = 32'h1357_2468;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL hold_accept: got %b want 1", ok); end
        n_cmp++; if (dwr_en !== 1'b1) begin n_err++; $display("FAIL hold_dwr_en: got %b want 1", dwr_en); end
        n_cmp++; if (dwr_way !== 2'd1) begin n_err++; $display("FAIL hold_dwr_way: got %0d want 1", dwr_way); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_resp_valid[%0d]: got %b want 1", i, resp_valid); end
            n_cmp++; if ({resp_hit, resp_way} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL hold_payload[%0d]: got hit=%b way=%0d want hit=1 way=1", i, resp_hit, resp_way); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
            n_cmp++; if (dwr_en !== 1'b0) begin n_err++; $display("FAIL hold_dwr_en[%0d]: got %b want 0", i, dwr_en); end
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, resp_valid} !== 2'b00) begin n_err++; $display("FAIL hold_release: got busy=%b rv=%b want 0/0", busy, resp_valid); end
    endtask

    task automatic test_flush();
        int cycles;
        int pulses;
        int done_at;
        int dwr_seen;
        cycles = 0; pulses = 0; done_at = -1; dwr_seen = 0;
        flush_req    = 1'b1;
        req_valid    = 1'b1;
        req_tagcheck = 1'b1;
        req_index    = 6'd5;
        req_tag      = 20'h00123;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_req_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        flush_req = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            cycles++;
            if (flush_done) begin pulses++; done_at = cycles; end
            if (dwr_en) dwr_seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (cycles != 64) begin n_err++; $display("FAIL flush_cycles: got %0d want 64", cycles); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
        n_cmp++; if (done_at != 64) begin n_err++; $display("FAIL flush_done_cycle: got %0d want 64", done_at); end
        n_cmp++; if (dwr_seen != 0) begin n_err++; $display("FAIL flush_dwr: got %0d want 0", dwr_seen); end
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL flush_done_after: got %b want 0", flush_done); end
        do_req(1'b1, 6'd5, 6'd7, 20'h00123, 2'd0, 32'h0);
        n_cmp++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL postflush_hit: got %b want 0", c_hit); end
        n_cmp++; if ({c_vway, c_vdirty} !== {2'd0, 1'b0}) begin n_err++; $display("FAIL postflush_victim: got way=%0d dirty=%b want 0/0", c_vway, c_vdirty); end
        n_cmp++; if (c_dwr_cnt != 0) begin n_err++; $display("FAIL postflush_dwr_cnt: got %0d want 0", c_dwr_cnt); end
    endtask

    task automatic test_reset_mid_flush();
        do_req(1'b0, 6'd40, 6'd0, 20'h00040, 2'd1, 32'h0);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstflush_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstflush_busy: got %b want 0", busy); end
        n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL rstflush_done: got %b want 0", flush_done); end
        n_cmp++; if ({dwr_en, resp_valid, req_ready} !== 3'b001) begin n_err++; $display("FAIL rstflush_outs: got %b want 001", {dwr_en, resp_valid, req_ready}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 6'd40, 6'd0, 20'h00040, 2'd0, 32'h0);
        n_cmp++; if (c_hit !== 1'b0) begin n_err++; $display("FAIL rstflush_hit: got %b want 0", c_hit); end
        n_cmp++; if (c_vway !== 2'd0) begin n_err++; $display("FAIL rstflush_vway: got %0d want 0", c_vway); end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_tagcheck = 1'b0;
        req_index    = '0;
        req_line     = '0;
        req_tag      = '0;
        req_way      = '0;
        req_data     = '0;
        flush_req    = 1'b0;
        resp_ready   = 1'b1;

        test_reset();
        test_store_miss_empty();
        test_fill();
        test_store_hit();
        test_dirty_victim();
        test_plru_full();
        test_back_to_back();
        test_resp_hold();
        test_flush();
        test_reset_mid_flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_write_unit.md
# dcache_write_unit

Write-side engine of the data cache, the counterpart to the read path: it accepts store requests (tag-checked) and line-fill writes (no tag check), owns the per-set tag/valid/dirty/PLRU metadata, and drives the data-array write port. It also performs a sequential whole-cache flush. It sits between the memory unit's request arbiter and the data RAM.

## Interface
- NUM_OF_SETS, 64, sets in the cache; power of two.
- WAY_PER_SET, 4, associativity; fixed at 4 for tree PLRU.
- TAG_SIZE, 20, tag bits.
- WORD_SIZE, 32, data word bits.
- LINE_W, 6, word-in-line index bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  write request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_tagcheck  in  1  1 = store with tag check; 0 = fill to req_way.
- req_index  in  $clog2(NUM_OF_SETS)  set index.
- req_line  in  LINE_W  word within line.
- req_tag  in  TAG_SIZE  tag.
- req_way  in  $clog2(WAY_PER_SET)  target way for fills; ignored for stores.
- req_data  in  WORD_SIZE  write data.
- flush_req  in  1  start full flush (sampled in IDLE).
- dwr_en  out  1  data-array write strobe, one cycle.
- dwr_index / dwr_line / dwr_way / dwr_data  out  set/line/way/word widths  data-array write address and data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_hit  out  1  store hit, or 1 for a fill.
- resp_way  out  $clog2(WAY_PER_SET)  way written.
- resp_victim_way  out  $clog2(WAY_PER_SET)  eviction candidate on store miss.
- resp_victim_dirty  out  1  candidate valid && dirty.
- resp_victim_tag  out  TAG_SIZE  candidate tag.
- busy  out  1  state != IDLE.
- flush_done  out  1  one-cycle pulse when flush completes.

## Operation
- FSM states: IDLE, LOOKUP, RESP, FLUSH.
- IDLE: req_ready = !flush_req. flush_req=1 goes to FLUSH and takes priority over req_valid. A handshake latches the request and goes to LOOKUP.
- LOOKUP (1 cycle): compare the latched tag against valid ways of the set.
  - Store hit on way w: dwr_en=1 with the latched fields and dwr_way=w. At the edge, set dirty[w] and update PLRU.
  - Store miss: no write and no metadata change. Victim is the lowest-index invalid way; if all ways are valid, the PLRU victim is used.
  - Fill: dwr_en=1 to req_way. At the edge, set tag[req_way]=req_tag, valid=1, dirty=0, and update PLRU.
  - Always proceeds to RESP.
- RESP: resp_valid=1. Payload stays stable until resp_ready, then the FSM returns to IDLE.
- FLUSH: a counter walks sets 0..NUM_OF_SETS-1, one per cycle, clearing valid, dirty and PLRU. After the last set, flush_done pulses for one cycle and the FSM returns to IDLE.
- PLRU uses 3 bits per set [b2 b1 b0].
  - Victim: b0=0 gives way {0,b1}; b0=1 gives way {1,b2}.
  - Access to way w<2: b0=1, b1=~w[0]. Access to way w>=2: b0=0, b2=~w[0].
- Reset: all valid, dirty and PLRU bits are 0; tags are 0; FSM goes to IDLE.

## Timing
- Request accepted at edge N; dwr_en high during cycle N+1; resp_valid from cycle N+2.
- Minimum 3 cycles per request; there is no pipelining.
- A fill or store response immediately followed by another request sees the updated metadata.
- Flush takes NUM_OF_SETS cycles in FLUSH, with flush_done in the last of those cycles (index NUM_OF_SETS-1).
- Output reset values:
  - 0: resp_valid, dwr_en, busy, flush_done.
  - req_ready = !flush_req.
  - All resp_* and dwr_* payloads are 0.
- Reset asserted mid-LOOKUP, mid-RESP or mid-FLUSH forces all outputs to their reset values immediately. Pending work is discarded.
- req_valid outside IDLE is ignored; the requester holds it.

## Test plan
- After reset, store set 5 tag 0x00123 -> resp_hit=0, victim_way=0, victim_dirty=0, dwr_en never high.
- Fill set 5 way 2 tag 0x00123 line 3 data 0xDEADBEEF -> dwr_en one cycle with (5,3,2,0xDEADBEEF), resp_hit=1, resp_way=2. Then store the same tag/set -> hit way 2; a follow-up miss in a full set 5 reports dirty for way 2 when selected.
- Fill set 7 ways 0,1,2,3 in order, then store with a new tag -> miss, victim_way=0 (PLRU=000), victim_dirty=0.
- Assert flush_req and req_valid in the same IDLE cycle -> req_ready=0, FLUSH runs 64 cycles, flush_done pulses once. Then a store to the earlier-hit line misses.
- Hold resp_ready=0 for 5 cycles -> resp_valid and payload constant, req_ready=0, no second dwr_en.
- Drop rst_n during cycle 10 of FLUSH -> busy=0, flush_done=0 immediately. A later store to any set misses with victim_way=0.
